// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg
//   Shared helpers for the Gray-code counter and for anything that consumes
//   its output:
//     GRAY_MAX_WIDTH : widest counter the block supports.
//     bin2gray(b)    : binary -> reflected Gray code.
//     gray2bin(g)    : reflected Gray code -> binary, via a prefix XOR from the MSB.
//   Both functions work on GRAY_MAX_WIDTH-bit values. Narrower callers
//   zero-extend their input and truncate the result.
package gray_counter_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of every Gray bit at or above it.
    // Leading zeros from zero-extension leave the result unchanged.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
        logic [GRAY_MAX_WIDTH-1:0] b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// gray_counter
//   Free-running Gray-code counter. A binary count b steps once per rising
//   clock edge. Its Gray encoding is registered on the same edge, so out is
//   glitch-free and changes exactly one bit per step. That makes out safe to
//   sample from another clock domain.
//
//   Parameters:
//     WIDTH : counter/output width, 2..32.
//     DOWN  : 0 = ascending sequence, 1 = descending.
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   asynchronous active-low reset; clears b and out
//     out     out  [WIDTH-1:0] registered Gray code, always Gray(b)
//     tc      out  terminal count: b == all-ones (up) or b == 0 (down)
//     bin_out out  [WIDTH-1:0] internal binary count; present only when
//                  GRAY_COUNTER_BIN_OUT_EN is defined
//   Build option:
//     GRAY_COUNTER_BIN_OUT_EN : expose the binary count on bin_out.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef GRAY_COUNTER_BIN_OUT_EN
    output logic [WIDTH-1:0] bin_out,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("gray_counter: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] next_b;

    assign next_b = DOWN ? (b - WIDTH'(1)) : (b + WIDTH'(1));

    // out is converted from next_b rather than from b. It is then registered
    // on the same edge as b, so out equals Gray(b) with no extra cycle of lag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b   <= '0;
            out <= '0;
        end else begin
            b   <= next_b;
            out <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(next_b)));
        end
    end

    // tc decodes the register directly. It is high in the same cycle that
    // out shows the last code before wrap.
    assign tc = DOWN ? (b == '0) : (b == '1);

`ifdef GRAY_COUNTER_BIN_OUT_EN
    assign bin_out = b;
`endif

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;
    import gray_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] out4;
    logic       tc4;
    logic [2:0] out3;
    logic       tc3;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [3:0] bin4;
    logic [2:0] bin3;
`endif

    gray_counter #(.WIDTH(4), .DOWN(1'b0)) u_up (
        .clk(clk), .rst(rst),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_out(bin4),
`endif
        .out(out4), .tc(tc4)
    );

    gray_counter #(.WIDTH(3), .DOWN(1'b1)) u_dn (
        .clk(clk), .rst(rst),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_out(bin3),
`endif
        .out(out3), .tc(tc3)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] out;
        logic       tc;
    } up_vec_t;

    typedef struct {
        logic [2:0] out;
        logic       tc;
        logic [2:0] bin;
    } dn_vec_t;

    up_vec_t up_tbl[16];
    dn_vec_t dn_tbl[8];

    // Reference counts, advanced with plain modular arithmetic.
    int cnt4, cnt3;
    logic [3:0] prev4;
    logic [2:0] prev3;

    // Pulse reset shortly after a rising edge and release it before the next
    // one. Outputs must already be zero while reset is still low.
    task automatic async_reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_async_out4"}, 32'(out4), 32'd0);
        chk({tag, "_async_out3"}, 32'(out3), 32'd0);
        #2;
        rst = 1'b1;
        cnt4 = 0; cnt3 = 0; prev4 = '0; prev3 = '0;
    endtask

    task automatic step_and_check(input string tag);
        @(posedge clk);
        #1;
        cnt4 = (cnt4 + 1) % 16;
        cnt3 = (cnt3 + 7) % 8;
        chk({tag, "_out4"}, 32'(out4), 32'(cnt4 ^ (cnt4 >> 1)));
        chk({tag, "_tc4"}, 32'(tc4), 32'(cnt4 == 15));
        chk({tag, "_out3"}, 32'(out3), 32'(cnt3 ^ (cnt3 >> 1)));
        chk({tag, "_tc3"}, 32'(tc3), 32'(cnt3 == 0));
        chk({tag, "_ham4"}, 32'($countones(out4 ^ prev4)), 32'd1);
        chk({tag, "_ham3"}, 32'($countones(out3 ^ prev3)), 32'd1);
        chk({tag, "_g2b4"}, gray2bin(32'(out4)), 32'(cnt4));
`ifdef GRAY_COUNTER_BIN_OUT_EN
        chk({tag, "_bin4"}, 32'(bin4), 32'(cnt4));
        chk({tag, "_bin3"}, 32'(bin3), 32'(cnt3));
`endif
        prev4 = out4;
        prev3 = out3;
    endtask

    initial begin
        up_tbl = '{
            '{4'b0001, 1'b0}, '{4'b0011, 1'b0}, '{4'b0010, 1'b0}, '{4'b0110, 1'b0},
            '{4'b0111, 1'b0}, '{4'b0101, 1'b0}, '{4'b0100, 1'b0}, '{4'b1100, 1'b0},
            '{4'b1101, 1'b0}, '{4'b1111, 1'b0}, '{4'b1110, 1'b0}, '{4'b1010, 1'b0},
            '{4'b1011, 1'b0}, '{4'b1001, 1'b0}, '{4'b1000, 1'b1}, '{4'b0000, 1'b0}
        };
        dn_tbl = '{
            '{3'b100, 1'b0, 3'd7}, '{3'b101, 1'b0, 3'd6}, '{3'b111, 1'b0, 3'd5},
            '{3'b110, 1'b0, 3'd4}, '{3'b010, 1'b0, 3'd3}, '{3'b011, 1'b0, 3'd2},
            '{3'b001, 1'b0, 3'd1}, '{3'b000, 1'b1, 3'd0}
        };

        // Hold reset across two rising edges.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out4", 32'(out4), 32'd0);
        chk("reset_tc4", 32'(tc4), 32'd0);
        chk("reset_out3", 32'(out3), 32'd0);
        chk("reset_tc3", 32'(tc3), 32'd1);

        // Full up sequence for WIDTH=4 and, in parallel, the down sequence for WIDTH=3.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("up_seq%0d_out", i), 32'(out4), 32'(up_tbl[i].out));
            chk($sformatf("up_seq%0d_tc", i), 32'(tc4), 32'(up_tbl[i].tc));
            if (i < 8) begin
                chk($sformatf("dn_seq%0d_out", i), 32'(out3), 32'(dn_tbl[i].out));
                chk($sformatf("dn_seq%0d_tc", i), 32'(tc3), 32'(dn_tbl[i].tc));
`ifdef GRAY_COUNTER_BIN_OUT_EN
                chk($sformatf("dn_seq%0d_bin", i), 32'(bin3), 32'(dn_tbl[i].bin));
`endif
            end
        end

        // Mid-count reset: advance to 0110, pulse reset, and expect 0001 on the next edge.
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        chk("mid_reach_0110", 32'(out4), 32'b0110);
        async_reset_pulse("mid");
        @(posedge clk);
        #1;
        chk("mid_first_after_release", 32'(out4), 32'b0001);
        chk("mid_dn_first_after_release", 32'(out3), 32'b100);

        // Randomized run against the arithmetic model, with occasional reset pulses.
        cnt4 = 1; cnt3 = 7; prev4 = out4; prev3 = out3;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) async_reset_pulse("rnd");
            step_and_check("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Free-running, parameterisable Gray-code counter.
- Advances one code per rising clock edge whenever out of reset.
- Exactly one output bit changes per step, so the value can be sampled safely across clock domains (e.g. FIFO pointers, position encoders).
- Internally a binary counter feeds a registered binary-to-Gray conversion, so the output is glitch-free.

Parameters:
- WIDTH, 4, counter and output width in bits; legal range 2..32.
- DOWN, 0, count direction: 0 = ascending Gray sequence, 1 = descending.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-low.
- out  output WIDTH  registered Gray-code count.
- tc  output 1  terminal-count flag; high while out holds the last code before wrap.

Behaviour:
- Reset
  - rst low clears the internal binary count b and out to 0 immediately, regardless of clk.
  - tc is derived from b and is therefore 0 during reset when DOWN=0.
  - Reset is asynchronous on assertion. Release is used directly; no internal synchroniser.
- Counting, DOWN=0
  - On each rising clk edge with rst high: b <= b + 1, modulo 2^WIDTH.
  - out <= next_b XOR (next_b >> 1), registered in the same edge, so out always equals Gray(b).
  - Latency: first change appears on the first rising edge after rst goes high.
  - Sequence for WIDTH=4: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000 (period 16).
- Counting, DOWN=1
  - b <= b - 1 modulo 2^WIDTH.
  - From reset the first code is Gray(2^WIDTH-1), i.e. 1000 for WIDTH=4.
- Wrap-around
  - Natural modulo arithmetic; no saturation, no extra cycle.
  - The last-to-first transition also changes exactly one bit (1000 -> 0000).
- tc
  - DOWN=0: high when b == 2^WIDTH-1.
  - DOWN=1: high when b == 0.
  - Combinational decode of the register (no added latency).
- Invariant: Hamming distance between consecutive out values is exactly 1 on every counting edge.
- Reset mid-count: out returns to 0 at once; counting resumes from the reset code after release.
- No X on out or tc at any time after the first reset assertion.

Optional Feature:
- Macro GRAY_COUNTER_BIN_OUT_EN.
  - Defined: adds output port bin_out [WIDTH-1:0], equal to the internal binary count b, same timing as out, reset value 0.
  - Undefined: port absent; b stays internal. Gray behaviour is identical in both builds.

Decomposition:
- Package gray_counter_pkg holds:
  - function bin2gray(b) = b ^ (b >> 1);
  - function gray2bin(g), prefix XOR from MSB, used by benches and downstream consumers;
  - localparam for the maximum supported WIDTH (32).
- No sub-module needed. The counter register and conversion fit naturally in one module.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, toggling clk -> out=0000, tc=0.
- Async assertion: assert rst between clock edges -> out=0000 immediately, not at the next edge.
- Full up sequence: release rst, apply 16 rising edges -> out steps 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - tc high only while out=1000.
- One-bit invariant: run 100 edges -> every transition flips exactly 1 bit, and gray2bin(out) increments by 1 mod 16.
- Reset mid-count: reach out=0110, pulse rst low for half a cycle -> out=0000 at once; first edge after release gives 0001.
- Parameter variants:
  - WIDTH=3, DOWN=1: from reset, edges give 100, 101, 111, 110, 010, 011, 001, 000.
  - With GRAY_COUNTER_BIN_OUT_EN defined: bin_out tracks 7, 6, ... 0.
